// File: rtl/sume_pkg.sv
// -----------------------------------------------------------------------------
// sume_pkg
// Shared definitions for the keypad digit-entry controller:
//   state_t    - controller state encoding
//   KEY_*      - keypad codes that are not digits
//   is_digit_key() - true for keypad codes 0..9
// -----------------------------------------------------------------------------
package sume_pkg;

    typedef enum logic [2:0] {
        ENTER_A   = 3'd0,
        ENTER_B   = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        SHOW      = 3'd4
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    function automatic logic is_digit_key(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_shreg.sv
// -----------------------------------------------------------------------------
// bcd_digit_shreg
// NUM_DIGITS-deep shift register of 4-bit BCD digits with a saturating count
// of how many digits have been entered.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset
//   i_clr    - zero the value and the count
//   i_load   - replace the contents with i_digit alone (count becomes 1)
//   i_shift  - shift i_digit in as the new least significant digit
//   i_digit  - digit to load or shift
//   o_value  - current register contents, first digit entered is the MSD
//   o_count  - digits entered so far, saturating at NUM_DIGITS
// Priority: reset > i_clr > i_load > i_shift.
// -----------------------------------------------------------------------------
module bcd_digit_shreg
    import sume_pkg::*;
#(
    parameter  int NUM_DIGITS = 3,
    localparam int DW         = 4 * NUM_DIGITS,
    localparam int CW         = $clog2(NUM_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic [3:0]    i_digit,
    output logic [DW-1:0] o_value,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_value;
    logic [CW-1:0] r_count;
    logic [DW-1:0] w_shifted;

    // A single-digit register has nothing to shift up, so the new digit
    // simply replaces the old one.
    if (NUM_DIGITS > 1) begin : g_multi
        assign w_shifted = {r_value[DW-5:0], i_digit};
    end else begin : g_single
        assign w_shifted = DW'(i_digit);
    end

    // Digit storage and entered-digit count; the count never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_value <= DW'(i_digit);
            r_count <= CW'(1);
        end else if (i_shift) begin
            r_value <= w_shifted;
            if (r_count != CW'(NUM_DIGITS)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;

endmodule

// File: rtl/digit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// digit_entry_ctrl
// Keypad front end for a BCD adder: collects two NUM_DIGITS-digit operands,
// launches the adder, waits for its result and shows it.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   key_code     - keypad code (0-9 digit, A enter, B clear, C-F ignored)
//   key_valid    - one-cycle strobe qualifying key_code
//   op_a, op_b   - operands to the adder
//   add_start    - one-cycle adder launch pulse
//   add_done     - adder completion strobe
//   add_result   - BCD sum, valid with add_done
//   disp         - display word (active operand, or latched result)
//   busy         - high while the adder is running
//   err          - adder timeout flag
// Configuration:
//   ENTRY_TIMEOUT_EN - when defined, give up on the adder after
//                      TIMEOUT_CYCLES cycles, flag err and show EEEE.
//                      Otherwise wait forever and tie err low.
// -----------------------------------------------------------------------------
module digit_entry_ctrl
    import sume_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  key_code,
    input  logic                        key_valid,
    output logic [4*NUM_DIGITS-1:0]     op_a,
    output logic [4*NUM_DIGITS-1:0]     op_b,
    output logic                        add_start,
    input  logic                        add_done,
    input  logic [4*(NUM_DIGITS+1)-1:0] add_result,
    output logic [4*(NUM_DIGITS+1)-1:0] disp,
    output logic                        busy,
    output logic                        err
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int RW = 4 * (NUM_DIGITS + 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [RW-1:0] r_result;
    logic [CW-1:0] w_cnt_a;
    logic [CW-1:0] w_cnt_b;

    logic w_is_digit;
    logic w_is_enter;
    logic w_is_clear;
    logic w_clear_all;
    logic w_clr_b;
    logic w_load_a;
    logic w_shift_a;
    logic w_shift_b;
    logic w_latch_result;
    logic w_timeout;
    logic w_tmo_hit;

    // Key decode; anything without key_valid, and codes C-F, decode to nothing.
    assign w_is_digit = key_valid && is_digit_key(key_code);
    assign w_is_enter = key_valid && (key_code == KEY_ENTER);
    assign w_is_clear = key_valid && (key_code == KEY_CLEAR);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ENTER_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath controls. LAUNCH and WAIT_DONE have no key
    // handling at all, which is what makes every key (even clear) a no-op
    // while busy.
    always_comb begin
        w_next_state   = r_state;
        w_clear_all    = 1'b0;
        w_clr_b        = 1'b0;
        w_load_a       = 1'b0;
        w_shift_a      = 1'b0;
        w_shift_b      = 1'b0;
        w_latch_result = 1'b0;
        w_timeout      = 1'b0;

        case (r_state)
            ENTER_A: begin
                if (w_is_clear) begin
                    w_clear_all  = 1'b1;
                    w_next_state = ENTER_A;
                end else if (w_is_digit) begin
                    w_shift_a = 1'b1;
                    // The count still holds the pre-shift value here.
                    if (w_cnt_a >= CW'(NUM_DIGITS - 1)) begin
                        w_next_state = ENTER_B;
                    end
                end else if (w_is_enter) begin
                    w_next_state = ENTER_B;
                end
            end

            ENTER_B: begin
                if (w_is_clear) begin
                    w_clear_all  = 1'b1;
                    w_next_state = ENTER_A;
                end else if (w_is_digit) begin
                    w_shift_b = 1'b1;
                    if (w_cnt_b >= CW'(NUM_DIGITS - 1)) begin
                        w_next_state = LAUNCH;
                    end
                end else if (w_is_enter && (w_cnt_b != '0)) begin
                    w_next_state = LAUNCH;
                end
            end

            LAUNCH: begin
                w_next_state = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (add_done) begin
                    w_latch_result = 1'b1;
                    w_next_state   = SHOW;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_next_state = SHOW;
                end
            end

            SHOW: begin
                if (w_is_clear) begin
                    w_clear_all  = 1'b1;
                    w_next_state = ENTER_A;
                end else if (w_is_digit) begin
                    // A digit starts a fresh calculation with that digit
                    // already entered as the first digit of A.
                    w_clr_b      = 1'b1;
                    w_load_a     = 1'b1;
                    w_next_state = ENTER_A;
                end
            end

            default: begin
                w_next_state = ENTER_A;
            end
        endcase
    end

    bcd_digit_shreg #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_op_a (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clear_all),
        .i_load  (w_load_a),
        .i_shift (w_shift_a),
        .i_digit (key_code),
        .o_value (op_a),
        .o_count (w_cnt_a)
    );

    bcd_digit_shreg #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_op_b (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clear_all | w_clr_b),
        .i_load  (1'b0),
        .i_shift (w_shift_b),
        .i_digit (key_code),
        .o_value (op_b),
        .o_count (w_cnt_b)
    );

    // Result shown in SHOW: the adder sum, or all-E digits after a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
        end else if (w_clear_all) begin
            r_result <= '0;
        end else if (w_latch_result) begin
            r_result <= add_result;
        end else if (w_timeout) begin
            r_result <= {(NUM_DIGITS + 1){4'hE}};
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;

    // Counts cycles spent in WAIT_DONE; restarts from zero on every launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_DONE) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Expires at the end of the TIMEOUT_CYCLES-th waiting cycle.
    assign w_tmo_hit = (r_state == WAIT_DONE) &&
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Error flag survives into SHOW and is dropped when a new entry begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (w_clear_all || w_load_a) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign err       = 1'b0;
`endif

    // Display follows whatever the user is looking at; during the adder run
    // the last operand entered stays visible.
    always_comb begin
        disp = {4'h0, op_b};
        case (r_state)
            ENTER_A: disp = {4'h0, op_a};
            ENTER_B: disp = {4'h0, op_b};
            SHOW:    disp = r_result;
            default: disp = {4'h0, op_b};
        endcase
    end

    assign add_start = (r_state == LAUNCH);
    assign busy      = (r_state == LAUNCH) || (r_state == WAIT_DONE);

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_entry_ctrl
// Drives digit_entry_ctrl with directed key sequences followed by random
// keys, plays the part of the BCD adder, and compares every cycle against a
// behavioural model of the keypad rules kept in decimal/arithmetic form.
// Define ENTRY_TIMEOUT_EN for both bench and RTL to exercise the timeout.
// -----------------------------------------------------------------------------
module tb_digit_entry_ctrl;
    import sume_pkg::*;

    localparam int N       = 3;
    localparam int TIMEOUT = 16;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int PH_A      = 0;
    localparam int PH_B      = 1;
    localparam int PH_LAUNCH = 2;
    localparam int PH_WAIT   = 3;
    localparam int PH_SHOW   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_code = KEY_NONE;
    logic        key_valid = 1'b0;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        add_start;
    logic        add_done = 1'b0;
    logic [15:0] add_result = '0;
    logic [15:0] disp;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int startPulses = 0;
    bit cmpEn = 1'b0;

    // Behavioural model state
    int mPhase = PH_A;
    int mA = 0;
    int mB = 0;
    int mCa = 0;
    int mCb = 0;
    int mWait = 0;
    int mErr = 0;
    int mResult = 0;

    digit_entry_ctrl #(
        .NUM_DIGITS     (N),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .add_start  (add_start),
        .add_done   (add_done),
        .add_result (add_result),
        .disp       (disp),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic int bcdToInt(input int v);
        int r = 0;
        for (int i = N; i >= 0; i--) begin
            r = r * 10 + ((v >> (4 * i)) & 15);
        end
        return r;
    endfunction

    function automatic int intToBcd(input int v);
        int r = 0;
        int s = v;
        for (int i = 0; i <= N; i++) begin
            r = r | ((s % 10) << (4 * i));
            s = s / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] bcdAdd(input int a, input int b);
        return 16'(intToBcd(bcdToInt(a) + bcdToInt(b)));
    endfunction

    function automatic int expDisp();
        if (mPhase == PH_A) return mA;
        if (mPhase == PH_B) return mB;
        return mResult;
    endfunction

    task automatic checkOutput(input string name, input int unsigned actual,
                               input int unsigned expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelClearAll();
        mA = 0; mB = 0; mCa = 0; mCb = 0; mErr = 0; mResult = 0;
        mPhase = PH_A;
    endtask

    // One clock edge of the keypad rules.
    task automatic modelStep(input logic rst, input logic [3:0] kc,
                             input logic kv, input logic done,
                             input logic [15:0] res);
        bit dig = kv && (kc <= 4'd9);
        bit ent = kv && (kc == KEY_ENTER);
        bit clr = kv && (kc == KEY_CLEAR);
        int d   = int'(kc);
        if (rst) begin
            modelClearAll();
            mWait = 0;
        end else begin
            case (mPhase)
                PH_A: begin
                    if (clr) modelClearAll();
                    else if (dig) begin
                        mA  = (mA * 16 + d) % (1 << (4 * N));
                        mCa = (mCa < N) ? mCa + 1 : N;
                        if (mCa == N) mPhase = PH_B;
                    end else if (ent) mPhase = PH_B;
                end
                PH_B: begin
                    if (clr) modelClearAll();
                    else if (dig) begin
                        mB  = (mB * 16 + d) % (1 << (4 * N));
                        mCb = (mCb < N) ? mCb + 1 : N;
                        if (mCb == N) mPhase = PH_LAUNCH;
                    end else if (ent && mCb > 0) mPhase = PH_LAUNCH;
                end
                PH_LAUNCH: begin
                    mPhase = PH_WAIT;
                    mWait  = 0;
                end
                PH_WAIT: begin
                    if (done) begin
                        mResult = int'(res);
                        mPhase  = PH_SHOW;
                    end else begin
                        mWait++;
                        if (TMO_EN && mWait >= TIMEOUT) begin
                            mErr    = 1;
                            mResult = 16'hEEEE;
                            mPhase  = PH_SHOW;
                        end
                    end
                end
                PH_SHOW: begin
                    if (clr) modelClearAll();
                    else if (dig) begin
                        mA = d; mB = 0; mCa = 1; mCb = 0; mErr = 0;
                        mPhase = PH_A;
                    end
                end
                default: mPhase = PH_A;
            endcase
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, return at negedge.
    task automatic applyStimulus(input logic rst, input logic [3:0] kc,
                                 input logic kv, input logic done,
                                 input logic [15:0] res);
        reset      = rst;
        key_code   = kc;
        key_valid  = kv;
        add_done   = done;
        add_result = res;
        @(posedge clk);
        modelStep(rst, kc, kv, done, res);
        @(negedge clk);
    endtask

    task automatic pressKey(input logic [3:0] kc);
        applyStimulus(1'b0, kc, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, KEY_NONE, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic finishAdd(input int latency);
        repeat (latency) idle();
        applyStimulus(1'b0, KEY_NONE, 1'b0, 1'b1, bcdAdd(mA, mB));
    endtask

    // Per-cycle comparison against the model, a little after each edge.
    always @(posedge clk) begin
        #2;
        if (cmpEn) begin
            checkOutput("op_a", op_a, mA);
            checkOutput("op_b", op_b, mB);
            checkOutput("add_start", add_start, (mPhase == PH_LAUNCH) ? 1 : 0);
            checkOutput("busy", busy,
                        (mPhase == PH_LAUNCH || mPhase == PH_WAIT) ? 1 : 0);
            checkOutput("err", err, mErr);
            if (mPhase != PH_LAUNCH && mPhase != PH_WAIT) begin
                checkOutput("disp", disp, expDisp());
            end
            if (add_start) startPulses++;
        end
    end

    initial begin
        int s0;
        logic [3:0] kc;

        // Reset
        applyStimulus(1'b1, KEY_NONE, 1'b0, 1'b0, 16'h0);
        cmpEn = 1'b1;
        applyStimulus(1'b1, KEY_NONE, 1'b0, 1'b0, 16'h0);
        checkOutput("rst_op_a", op_a, 0);
        checkOutput("rst_disp", disp, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);

        // Full-length entry of both operands launches automatically
        s0 = startPulses;
        pressKey(4'd5); pressKey(4'd3); pressKey(4'd4);
        pressKey(4'd9); pressKey(4'd6); pressKey(4'd1);
        checkOutput("s1_op_a", op_a, 12'h534);
        checkOutput("s1_op_b", op_b, 12'h961);
        checkOutput("s1_add_start", add_start, 1);
        idle();
        checkOutput("s1_start_drop", add_start, 0);
        finishAdd(2);
        checkOutput("s1_disp", disp, 16'h1495);
        checkOutput("s1_pulses", startPulses - s0, 1);

        // Short operands terminated with enter
        pressKey(4'd7); pressKey(KEY_ENTER); pressKey(4'd2); pressKey(KEY_ENTER);
        checkOutput("s2_op_a", op_a, 12'h007);
        checkOutput("s2_op_b", op_b, 12'h002);
        idle();
        finishAdd(1);
        checkOutput("s2_disp", disp, 16'h0009);

        // Clear mid-entry, then enter with no A digits
        pressKey(4'd1); pressKey(4'd2);
        checkOutput("s3_disp_12", disp, 16'h0012);
        pressKey(KEY_CLEAR);
        checkOutput("s3_clr_op_a", op_a, 0);
        checkOutput("s3_clr_disp", disp, 0);
        pressKey(KEY_ENTER);
        checkOutput("s3_b_op_a", op_a, 0);

        // Ignored inputs: enter with no B digits, code C, unqualified digit
        pressKey(KEY_ENTER);
        pressKey(4'hC);
        applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 16'h0);
        checkOutput("s4_op_b_held", op_b, 0);
        pressKey(4'd4);
        checkOutput("s4_disp_b", disp, 16'h0004);
        pressKey(KEY_ENTER);
        checkOutput("s4_busy", busy, 1);
        pressKey(4'd5); pressKey(KEY_CLEAR); pressKey(KEY_ENTER);
        checkOutput("s4_busy_op_a", op_a, 0);
        checkOutput("s4_busy_op_b", op_b, 12'h004);
        finishAdd(0);
        checkOutput("s4_disp", disp, 16'h0004);

        // Reset in ENTER_B with two digits, colliding with a key and add_done
        pressKey(KEY_CLEAR); pressKey(KEY_ENTER); pressKey(4'd3); pressKey(4'd4);
        checkOutput("s5_op_b", op_b, 12'h034);
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 16'h1234);
        checkOutput("s5_op_a", op_a, 0);
        checkOutput("s5_op_b0", op_b, 0);
        checkOutput("s5_disp", disp, 0);
        checkOutput("s5_busy", busy, 0);
        checkOutput("s5_start", add_start, 0);
        pressKey(4'd7);
        checkOutput("s5_a_again", disp, 16'h0007);

        // Adder that never answers
        pressKey(KEY_ENTER); pressKey(4'd1); pressKey(KEY_ENTER);
        idle();
`ifdef ENTRY_TIMEOUT_EN
        repeat (TIMEOUT - 1) idle();
        checkOutput("s6_err_early", err, 0);
        checkOutput("s6_busy_early", busy, 1);
        idle();
        checkOutput("s6_err", err, 1);
        checkOutput("s6_disp", disp, 16'hEEEE);
        pressKey(4'd3);
        checkOutput("s6_err_clr", err, 0);
        checkOutput("s6_op_a", op_a, 12'h003);
`else
        repeat (TIMEOUT + 4) idle();
        checkOutput("s6_still_busy", busy, 1);
        checkOutput("s6_err", err, 0);
        finishAdd(0);
        checkOutput("s6_disp", disp, 16'h0008);
`endif

        // Random keys, random adder strobes, occasional reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) kc = 4'($urandom_range(10, 15));
            else                          kc = 4'($urandom_range(0, 9));
            applyStimulus(($urandom_range(0, 63) == 0),
                          kc,
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 3) == 0),
                          16'($urandom));
        end
        idle();
        cmpEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_entry_ctrl.md
DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, BCD digits per operand.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles to wait for add_done.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_code, input, 4, keypad code: 0-9 digit, 4'hA enter, 4'hB clear, 4'hF no key.
REQ-006 SHALL have port key_valid, input, 1, one-cycle strobe qualifying key_code.
REQ-007 SHALL have port op_a, output, 4*NUM_DIGITS, operand A to the BCD adder.
REQ-008 SHALL have port op_b, output, 4*NUM_DIGITS, operand B to the BCD adder.
REQ-009 SHALL have port add_start, output, 1, one-cycle adder launch pulse.
REQ-010 SHALL have port add_done, input, 1, adder completion strobe.
REQ-011 SHALL have port add_result, input, 4*(NUM_DIGITS+1), BCD sum, valid with add_done.
REQ-012 SHALL have port disp, output, 4*(NUM_DIGITS+1), display word.
REQ-013 SHALL have port busy, output, 1, high in LAUNCH and WAIT_DONE.
REQ-014 SHALL have port err, output, 1, adder timeout flag.

Function
REQ-015 SHALL implement the states ENTER_A, ENTER_B, LAUNCH, WAIT_DONE and SHOW.
REQ-016 SHALL ignore key_code unless key_valid=1, and SHALL ignore codes 4'hC-4'hF in every state.
REQ-017 SHALL, in ENTER_A or ENTER_B, shift a digit key into the active operand as the new LSD, so the first digit entered ends as the MSD.
REQ-018 SHALL advance ENTER_A->ENTER_B automatically on the NUM_DIGITS-th digit, or earlier on enter; unentered high digits are 0.
REQ-019 SHALL advance ENTER_B->LAUNCH automatically on the NUM_DIGITS-th digit, or on enter if at least one B digit was entered.
REQ-020 SHALL ignore enter when pressed in ENTER_B with zero B digits entered.
REQ-021 SHALL, in LAUNCH, assert add_start for exactly one cycle, then move to WAIT_DONE; op_a and op_b SHALL be held stable from LAUNCH until SHOW is entered.
REQ-022 SHALL, in WAIT_DONE, latch add_result into disp and enter SHOW on add_done=1.
REQ-023 SHALL ignore add_done in all states other than WAIT_DONE.
REQ-024 SHALL drive disp zero-extended from the active operand during ENTER_A and ENTER_B, and from the latched result in SHOW.
REQ-025 SHALL, in SHOW, on a digit key, clear both operands and err, load that digit into op_a, and enter ENTER_A.
REQ-026 SHALL, in SHOW, ignore enter.
REQ-027 SHALL, on clear in ENTER_A, ENTER_B or SHOW, zero op_a, op_b, disp and err and enter ENTER_A.
REQ-028 SHALL ignore all keys while busy=1, including clear.
REQ-029 SHALL count digits saturating at NUM_DIGITS, with no wrap-around.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set state=ENTER_A, op_a=0, op_b=0, disp=0, add_start=0, busy=0, err=0 and digit counters=0.
REQ-031 SHALL give reset priority over every other event, including a mid-entry key and an add_done arriving in the same cycle.

Configuration
REQ-032 SHALL, with ENTRY_TIMEOUT_EN defined, count cycles in WAIT_DONE and, if add_done has not arrived after TIMEOUT_CYCLES cycles, set err=1, set disp to all 4'hE digits and enter SHOW.
REQ-033 SHALL, without ENTRY_TIMEOUT_EN, wait in WAIT_DONE indefinitely, tie err to 0 and omit the timeout counter.

Structure
REQ-034 SHALL take the state enum type and the key constants (KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_NONE=4'hF) from shared package sume_pkg.
REQ-035 SHALL use one sub-module, bcd_digit_shreg (NUM_DIGITS-deep 4-bit shift register with clear, load and count), instantiated once per operand.

Verification
REQ-036 Bench SHALL cover: keys 5,3,4,9,6,1 -> op_a=12'h534, op_b=12'h961, one add_start pulse; model returns 16'h1495 -> disp=16'h1495 in SHOW.
REQ-037 Bench SHALL cover: keys 7,enter,2,enter -> op_a=12'h007, op_b=12'h002; result 16'h0009 displayed.
REQ-038 Bench SHALL cover: keys 1,2,clear -> ENTER_A, op_a=0, disp=0; enter then pressed with no A digits -> ENTER_B, op_a=0.
REQ-039 Bench SHALL cover: key 4'hC, key_code=3 with key_valid=0, and keys pressed while busy -> no state or operand change.
REQ-040 Bench SHALL cover: reset asserted in ENTER_B after two digits -> all outputs return to their reset values on the next edge.
REQ-041 Bench SHALL cover, with ENTRY_TIMEOUT_EN: add_done withheld -> after 16 cycles err=1, disp=16'hEEEE; digit 3 then -> err=0, op_a=12'h003.
